// File: rtl/alu_wb_stage.sv
// Non-pipelined execute/write-back stage feeding a register file write port.
// Optional signed-overflow flag on port ovf when ALU_WB_OVF_EN is defined.
module alu_wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [15:0]       in_imm,
    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [ADDR_W-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              done
`ifdef ALU_WB_OVF_EN
    ,
    output logic              ovf
`endif
);

    localparam logic [2:0] OpAdd = 3'd0;
    localparam logic [2:0] OpSub = 3'd1;
    localparam logic [2:0] OpAnd = 3'd2;
    localparam logic [2:0] OpOr  = 3'd3;
    localparam logic [2:0] OpXor = 3'd4;
    localparam logic [2:0] OpSll = 3'd5;
    localparam logic [2:0] OpSrl = 3'd6;
    localparam logic [2:0] OpLi  = 3'd7;

    typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [15:0]       imm_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [DATA_W-1:0] result_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (in_valid) state_d = (in_op == OpLi) ? StExec : StRead;
            StRead: state_d = StExec;
            StExec: state_d = StWb;
            StWb:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        result_d = '0;
        unique case (op_q)
            OpAdd: result_d = a_q + b_q;
            OpSub: result_d = a_q - b_q;
            OpAnd: result_d = a_q & b_q;
            OpOr:  result_d = a_q | b_q;
            OpXor: result_d = a_q ^ b_q;
            OpSll: result_d = a_q << b_q[4:0];
            OpSrl: result_d = a_q >> b_q[4:0];
            OpLi:  result_d = {{(DATA_W-16){1'b0}}, imm_q};
            default: result_d = '0;
        endcase
    end

`ifdef ALU_WB_OVF_EN
    logic ovf_d;

    // Overflow: operands agree in sign (after negating B for SUB) but the result does not.
    always_comb begin
        ovf_d = 1'b0;
        if (op_q == OpAdd) begin
            ovf_d = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (result_d[DATA_W-1] != a_q[DATA_W-1]);
        end else if (op_q == OpSub) begin
            ovf_d = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (result_d[DATA_W-1] != a_q[DATA_W-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (state_q == StExec) begin
            ovf <= ovf_d;
        end else if (state_q == StWb) begin
            ovf <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            op_q      <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rf_raddr1 <= '0;
            rf_raddr2 <= '0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_q  <= in_op;
                        rd_q  <= in_rd;
                        imm_q <= in_imm;
                        // LI skips READ, so the read addresses keep their previous value.
                        if (in_op != OpLi) begin
                            rf_raddr1 <= in_rs1;
                            rf_raddr2 <= in_rs2;
                        end
                    end
                end
                StRead: begin
                    a_q <= rf_rdata1;
                    b_q <= rf_rdata2;
                end
                StExec: begin
                    rf_wdata <= result_d;
                    rf_waddr <= rd_q;
                end
                default: ;
            endcase
        end
    end

    assign in_ready = (state_q == StIdle) && rst_n;
    assign rf_we    = (state_q == StWb);
    assign done     = (state_q == StWb);

endmodule

// File: tb/tb_alu_wb_stage.sv
// Bench for alu_wb_stage: directed test-plan steps plus random instructions
// checked against an arithmetic reference model and a behavioural register file.
module tb_alu_wb_stage;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND = 3'd2, OR = 3'd3;
    localparam logic [2:0] XOR = 3'd4, SLL = 3'd5, SRL = 3'd6, LI = 3'd7;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [ADDR_W-1:0] in_rd, in_rs1, in_rs2;
    logic [15:0]       in_imm;
    logic [ADDR_W-1:0] rf_raddr1, rf_raddr2, rf_waddr;
    logic [DATA_W-1:0] rf_rdata1, rf_rdata2, rf_wdata;
    logic              rf_we, done;
`ifdef ALU_WB_OVF_EN
    logic              ovf;
`endif

    logic [DATA_W-1:0] regs [32];

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    alu_wb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .rf_raddr1 (rf_raddr1),
        .rf_raddr2 (rf_raddr2),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .done      (done)
`ifdef ALU_WB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // Behavioural register file: combinational reads, write on the rising edge.
    always_comb begin
        rf_rdata1 = regs[rf_raddr1];
        rf_rdata2 = regs[rf_raddr2];
    end

    always @(posedge clk) begin
        if (rf_we) regs[rf_waddr] <= rf_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [15:0] imm);
        longint unsigned s;
        case (op)
            ADD: begin s = longint'(a) + longint'(b); return s[31:0]; end
            SUB: begin s = longint'(a) + 64'h1_0000_0000 - longint'(b); return s[31:0]; end
            AND: return a & b;
            OR:  return a | b;
            XOR: return a ^ b;
            SLL: return a << (b % 32);
            SRL: return a >> (b % 32);
            default: return {16'h0, imm};
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == ADD)      r = sa + sb;
        else if (op == SUB) r = sa - sb;
        else                return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    task automatic scramble_inputs();
        in_valid = 1'($urandom % 2);
        in_op    = 3'($urandom);
        in_rd    = 5'($urandom);
        in_rs1   = 5'($urandom);
        in_rs2   = 5'($urandom);
        in_imm   = 16'($urandom);
    endtask

    // Issues one instruction at a negedge and checks every cycle until in_ready returns.
    task automatic run(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [15:0] imm);
        logic [31:0] exp_d;
        logic        exp_o;
        int          lat;
        exp_d = ref_result(op, regs[rs1], regs[rs2], imm);
        exp_o = ref_ovf(op, regs[rs1], regs[rs2]);
        lat   = (op == LI) ? 2 : 3;
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
        check("ready_before_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            if (c == 1 && op != LI) begin
                check("raddr1", 32'(rf_raddr1), 32'(rs1));
                check("raddr2", 32'(rf_raddr2), 32'(rs2));
            end
            if (c == lat) begin
                check("we_in_wb", 32'(rf_we), 32'd1);
                check("done_in_wb", 32'(done), 32'd1);
                check("waddr", 32'(rf_waddr), 32'(rd));
                check("wdata", rf_wdata, exp_d);
`ifdef ALU_WB_OVF_EN
                check("ovf_in_wb", 32'(ovf), 32'(exp_o));
`endif
            end else begin
                check("we_idle", 32'(rf_we | done), 32'd0);
            end
            if (c <= lat) begin
                check("busy_not_ready", 32'(in_ready), 32'd0);
                scramble_inputs();
            end else begin
                check("ready_after", 32'(in_ready), 32'd1);
                check("rf_written", regs[rd], exp_d);
`ifdef ALU_WB_OVF_EN
                check("ovf_cleared", 32'(ovf), 32'd0);
`endif
                in_valid = 1'b0;
            end
        end
        if (exp_o === 1'bx) $display("note: unexpected unknown overflow reference");
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_op    = '0;
        in_rd    = '0;
        in_rs1   = '0;
        in_rs2   = '0;
        in_imm   = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_we", 32'(rf_we | done), 32'd0);
        check("rst_waddr", 32'(rf_waddr), 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_raddr", 32'({rf_raddr1, rf_raddr2}), 32'd0);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", 32'(in_ready), 32'd1);
        @(negedge clk);

        run(LI, 5'd1, 5'd0, 5'd0, 16'hBEEF);
        check("li_r1", regs[1], 32'h0000BEEF);
        regs[1] = 32'hDEADBEEF;
        regs[2] = 32'hCAFEBABE;
        run(ADD, 5'd3, 5'd1, 5'd2, 16'h0);
        check("add_r3", regs[3], 32'hA9AC79AD);
        run(LI, 5'd5, 5'd0, 5'd0, 16'h1234);
        run(ADD, 5'd6, 5'd5, 5'd5, 16'h0);
        check("add_r6", regs[6], 32'h00002468);
        run(SUB, 5'd4, 5'd1, 5'd1, 16'h0);
        check("sub_r4", regs[4], 32'h0);
        run(LI, 5'd7, 5'd0, 5'd0, 16'd4);
        run(SRL, 5'd8, 5'd1, 5'd7, 16'h0);
        check("srl_r8", regs[8], 32'h0DEADBEE);
        run(SLL, 5'd9, 5'd1, 5'd7, 16'h0);
        check("sll_r9", regs[9], 32'hEADBEEF0);
        regs[1] = 32'h7FFFFFFF;
        regs[2] = 32'h00000001;
        run(ADD, 5'd10, 5'd1, 5'd2, 16'h0);
        check("ovf_add", regs[10], 32'h80000000);
        run(AND, 5'd11, 5'd1, 5'd2, 16'h0);
        run(SUB, 5'd12, 5'd10, 5'd2, 16'h0);
        run(ADD, 5'd0, 5'd0, 5'd0, 16'h0);

        // Reset during EXEC of an ADD: the write must never happen.
        regs[13] = 32'h13131313;
        in_valid = 1'b1;
        in_op    = ADD;
        in_rd    = 5'd13;
        in_rs1   = 5'd1;
        in_rs2   = 5'd2;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_we", 32'(rf_we | done), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd0);
        check("midrst_waddr", 32'(rf_waddr), 32'd0);
        check("midrst_wdata", rf_wdata, 32'd0);
        @(negedge clk);
        check("midrst_hold_we", 32'(rf_we), 32'd0);
        rst_n = 1'b1;
        #1;
        check("midrst_ready_after", 32'(in_ready), 32'd1);
        run(LI, 5'd14, 5'd0, 5'd0, 16'hA5A5);
        check("midrst_no_write", regs[13], 32'h13131313);

        for (int i = 0; i < 40; i++) begin
            run(3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
